// File: rtl/mem_access_unit.sv
// Data-memory initiator: turns CPU byte/half/word loads and stores into
// word-indexed req/ack transactions with byte enables, stalling the CPU meanwhile.
module mem_access_unit #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ex_valid,
  input  logic              ex_rw,
  input  logic [1:0]        ex_size,
  input  logic              ex_signed,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  output logic              stall,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              dbgState
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         latSize;
  logic [1:0]         latLane;
  logic               latSigned;

  logic               illegal;
  logic               timeoutHit;
  logic [3:0]         beNext;
  logic [31:0]        wdataNext;
  logic [7:0]         byteSel;
  logic [15:0]        halfSel;
  logic [31:0]        loadData;
  logic               unusedAddrBits;

  assign unusedAddrBits = ^ex_addr[31:ADDR_W+2];
  assign dbgState       = (state == REQ);

  assign illegal = (ex_size == 2'b11) ||
                   (ex_size == 2'b01 && ex_addr[0]) ||
                   (ex_size == 2'b10 && ex_addr[1:0] != 2'b00);

  assign timeoutHit = (cnt == CNT_W'(TIMEOUT - 1)) && !mem_ack;

  // Handshake: mem_req stays high from accept until the cycle mem_ack is seen
  // (or the timeout fires); stall releases the CPU in exactly that cycle.
  always_comb begin
    stall = 1'b0;
    if (RST) begin
      if (state == REQ) stall = !(mem_ack || timeoutHit);
      else              stall = ex_valid && !illegal;
    end
  end

  always_comb begin
    beNext    = 4'b1111;
    wdataNext = ex_wdata;
    case (ex_size)
      2'b00: begin
        beNext    = 4'b0001 << ex_addr[1:0];
        wdataNext = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        beNext    = 4'b0011 << {ex_addr[1], 1'b0};
        wdataNext = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byteSel  = mem_rdata[{latLane, 3'b000} +: 8];
    halfSel  = latLane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    loadData = mem_rdata;
    case (latSize)
      2'b00:   loadData = {{24{latSigned & byteSel[7]}}, byteSel};
      2'b01:   loadData = {{16{latSigned & halfSel[15]}}, halfSel};
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      latSize   <= 2'b00;
      latLane   <= 2'b00;
      latSigned <= 1'b0;
      ld_valid  <= 1'b0;
      ld_data   <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      ld_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (illegal) begin
              misalign <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= ex_rw;
              mem_addr  <= ex_addr[ADDR_W+1:2];
              mem_be    <= beNext;
              mem_wdata <= wdataNext;
              latSize   <= ex_size;
              latLane   <= ex_addr[1:0];
              latSigned <= ex_signed;
              cnt       <= '0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (!mem_we) begin
              ld_valid <= 1'b1;
              ld_data  <= loadData;
            end
          end else if (timeoutHit) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, signed/unsigned loads, misalign,
// timeout and mid-transaction reset, checked with immediate assertions.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_rw = 1'b0;
  logic [1:0]  ex_size = 2'b00;
  logic        ex_signed = 1'b0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic        stall, ld_valid, misalign, bus_err, mem_req, mem_we, dbgState;
  logic [31:0] ld_data, mem_wdata;
  logic [5:0]  mem_addr;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(6), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_rw(ex_rw), .ex_size(ex_size), .ex_signed(ex_signed),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbgState(dbgState)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the edge; checks happen 1 more unit later.
  task automatic present(input logic rw, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
    ex_valid  = 1'b1;
    ex_rw     = rw;
    ex_size   = size;
    ex_signed = sgn;
    ex_addr   = addr;
    ex_wdata  = wdata;
    #1;
  endtask

  // Load with an ack in the first REQ cycle; checks lanes, data and the pulse.
  task automatic do_load(input string tag, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [5:0] exp_addr,
                         input logic [31:0] exp_data);
    step();
    present(1'b0, size, sgn, addr, 32'h0);
    chk({tag, "_stall_accept"}, {31'b0, stall}, 32'd1);
    step();
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    ex_valid  = 1'b0;
    #1;
    chk({tag, "_req"}, {31'b0, mem_req}, 32'd1);
    chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
    chk({tag, "_be"}, {28'b0, mem_be}, {28'b0, exp_be});
    chk({tag, "_addr"}, {26'b0, mem_addr}, {26'b0, exp_addr});
    chk({tag, "_stall_ack"}, {31'b0, stall}, 32'd0);
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1;
    chk({tag, "_ldv"}, {31'b0, ld_valid}, 32'd1);
    chk({tag, "_ldd"}, ld_data, exp_data);
    chk({tag, "_req_drop"}, {31'b0, mem_req}, 32'd0);
    step();
    chk({tag, "_ldv_pulse"}, {31'b0, ld_valid}, 32'd0);
    chk({tag, "_ldd_hold"}, ld_data, exp_data);
  endtask

  task automatic do_misalign(input string tag, input logic [1:0] size, input logic [31:0] addr);
    step();
    present(1'b0, size, 1'b0, addr, 32'h0);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
    step();
    ex_valid = 1'b0;
    #1;
    chk({tag, "_pulse"}, {31'b0, misalign}, 32'd1);
    chk({tag, "_noreq"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_state"}, {31'b0, dbgState}, 32'd0);
    step();
    chk({tag, "_pulse_end"}, {31'b0, misalign}, 32'd0);
    chk({tag, "_noreq2"}, {31'b0, mem_req}, 32'd0);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_ldv", {31'b0, ld_valid}, 32'd0);
    chk("rst_ldd", ld_data, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    chk("rst_berr", {31'b0, bus_err}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", {26'b0, mem_addr}, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    step();
    RST = 1'b1;

    // word store, ack after two waiting cycles
    step();
    present(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
    chk("st_stall0", {31'b0, stall}, 32'd1);
    step();
    #1;
    chk("st_req", {31'b0, mem_req}, 32'd1);
    chk("st_we", {31'b0, mem_we}, 32'd1);
    chk("st_addr", {26'b0, mem_addr}, 32'd2);
    chk("st_be", {28'b0, mem_be}, 32'hF);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_stall1", {31'b0, stall}, 32'd1);
    step();
    #1;
    chk("st_stall2", {31'b0, stall}, 32'd1);
    step();
    mem_ack = 1'b1;
    #1;
    chk("st_stall_ack", {31'b0, stall}, 32'd0);
    step();
    mem_ack  = 1'b0;
    ex_valid = 1'b0;
    #1;
    chk("st_req_drop", {31'b0, mem_req}, 32'd0);
    chk("st_no_ldv", {31'b0, ld_valid}, 32'd0);
    chk("st_idle", {31'b0, dbgState}, 32'd0);

    // byte store lane replication
    step();
    present(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5);
    step();
    mem_ack  = 1'b1;
    ex_valid = 1'b0;
    #1;
    chk("stb_be", {28'b0, mem_be}, 32'h8);
    chk("stb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("stb_addr", {26'b0, mem_addr}, 32'd4);
    step();
    mem_ack = 1'b0;
    #1;
    chk("stb_no_ldv", {31'b0, ld_valid}, 32'd0);

    // byte and half loads
    do_load("lb1", 2'b00, 1'b1, 32'h0000_000D, 32'h1280_3456, 4'b0010, 6'd3, 32'h0000_0034);
    do_load("lb2", 2'b00, 1'b1, 32'h0000_000E, 32'h1280_3456, 4'b0100, 6'd3, 32'hFFFF_FF80);
    do_load("lbu", 2'b00, 1'b0, 32'h0000_000E, 32'h1280_3456, 4'b0100, 6'd3, 32'h0000_0080);
    do_load("lhu", 2'b01, 1'b0, 32'h0000_0006, 32'h8001_0000, 4'b1100, 6'd1, 32'h0000_8001);
    do_load("lhs", 2'b01, 1'b1, 32'h0000_0006, 32'h8001_0000, 4'b1100, 6'd1, 32'hFFFF_8001);
    do_load("lw", 2'b10, 1'b1, 32'hFFFF_FF04, 32'h8765_4321, 4'b1111, 6'd1, 32'h8765_4321);

    // misaligned / illegal
    do_misalign("mis_w", 2'b10, 32'h0000_0002);
    do_misalign("mis_h", 2'b01, 32'h0000_0001);
    do_misalign("mis_sz", 2'b11, 32'h0000_0000);

    // timeout: 15 REQ cycles, stall released in the last one
    step();
    present(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    chk("to_stall_accept", {31'b0, stall}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      step();
      #1;
      chk($sformatf("to_req_%0d", i), {31'b0, mem_req}, 32'd1);
      chk($sformatf("to_stall_%0d", i), {31'b0, stall}, (i == 14) ? 32'd0 : 32'd1);
    end
    step();
    ex_valid = 1'b0;
    #1;
    chk("to_req_drop", {31'b0, mem_req}, 32'd0);
    chk("to_berr", {31'b0, bus_err}, 32'd1);
    chk("to_idle", {31'b0, dbgState}, 32'd0);
    chk("to_no_ldv", {31'b0, ld_valid}, 32'd0);
    step();
    chk("to_berr_end", {31'b0, bus_err}, 32'd0);
    do_load("to_next", 2'b10, 1'b0, 32'h0000_0020, 32'h0BAD_F00D, 4'b1111, 6'd8, 32'h0BAD_F00D);

    // reset while waiting for ack
    step();
    present(1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0);
    step();
    step();
    chk("mr_req_before", {31'b0, mem_req}, 32'd1);
    RST = 1'b0;
    #1;
    chk("mr_req", {31'b0, mem_req}, 32'd0);
    chk("mr_stall", {31'b0, stall}, 32'd0);
    ex_valid = 1'b0;
    step();
    step();
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      mem_ack = (i == 3);
      #1;
      chk($sformatf("mr_ldv_%0d", i), {31'b0, ld_valid}, 32'd0);
      chk($sformatf("mr_berr_%0d", i), {31'b0, bus_err}, 32'd0);
      chk($sformatf("mr_req_%0d", i), {31'b0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: sits between the CPU execute stage and a word-organised data memory that acts as responder.
- Turns CPU load/store requests (byte, halfword or word, little-endian) into word-indexed memory transactions with byte enables, using a req/ack handshake.
- Stalls the CPU while a transaction is outstanding, extracts and extends load data, and reports misaligned accesses and timeouts.

Parameters:
- ADDR_W, 6, word-index width of the memory (64 words).
- TIMEOUT, 15, maximum number of REQ cycles without mem_ack before the transaction is abandoned.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- ex_valid  input  1  CPU requests an access this cycle.
- ex_rw  input  1  0 = read (load), 1 = write (store).
- ex_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- ex_signed  input  1  load extension: 1 = sign-extend, 0 = zero-extend.
- ex_addr  input  32  byte address.
- ex_wdata  input  32  store data, right-aligned.
- stall  output  1  CPU must hold all ex_* inputs stable while this is 1.
- ld_valid  output  1  one-cycle pulse; ld_data is valid.
- ld_data  output  32  extended load result.
- misalign  output  1  one-cycle pulse; request rejected.
- bus_err  output  1  one-cycle pulse; timeout occurred.
- mem_req  output  1  transaction request to memory.
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_W  word index, equal to ex_addr[ADDR_W+1:2]; upper address bits are ignored.
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  responder completion; may arrive in the first cycle of mem_req.
- mem_rdata  input  32  read word; sampled in the ack cycle.

Behaviour:
- Reset (asynchronous, RST=0): state IDLE, timeout counter 0. All registered outputs (ld_valid, ld_data, misalign, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata) are 0. stall is 0.
- Reset asserted mid-transaction aborts it immediately: mem_req drops, no ld_valid is produced, no error pulse is produced.
- States: IDLE, REQ.
- IDLE, ex_valid=1:
  - Misaligned or illegal request (size 11; half with addr[0]=1; word with addr[1:0]!=0): misalign pulses in the next cycle, stall stays 0, no memory request is made, state stays IDLE.
  - Legal request: stall=1 combinationally in that cycle. At the clock edge, register mem_req=1, mem_we=ex_rw, mem_addr, mem_be and mem_wdata; latch the size, lane and ex_signed; clear the counter; move to REQ.
- REQ:
  - stall = !mem_ack (combinational).
  - On mem_ack: mem_req drops next cycle, state returns to IDLE. For a read, ld_valid pulses next cycle with the extracted data. A store produces no ld_valid.
  - Without mem_ack: counter increments each cycle. When counter == TIMEOUT-1 and there is still no ack: mem_req drops, bus_err pulses next cycle, state returns to IDLE, and stall is 0 in that cycle.
- Nominal latency: accept in cycle N, mem_req from N+1; an ack in N+1 gives ld_valid in N+2. A new request is accepted in N+2, the same cycle as ld_valid.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load lanes: byte rdata[8*addr[1:0]+:8]; half rdata[16*addr[1]+:16]; word passes through unchanged. Sub-word loads are extended according to the latched ex_signed.
- mem_ack in IDLE is ignored. ex_* changes during REQ are ignored; values latched at accept are used.
- ld_data holds its last value between pulses.

Test Plan:
- Word store: addr 0x0000_0008, wdata 0xDEADBEEF, ack after 2 cycles -> mem_addr=2, mem_be=1111, mem_wdata=0xDEADBEEF, stall high for 3 cycles, no ld_valid.
- Signed byte load: addr 0x0000_000D, rdata 0x12_80_34_56, immediate ack -> mem_be=0010, ld_data=0x00000034 one cycle after ack. Repeat with lane 2 (addr 0x0E) -> ld_data=0xFFFFFF80.
- Unsigned half load: addr 0x0000_0006, rdata 0x8001_0000 -> ld_data=0x00008001. Same with ex_signed=1 -> ld_data=0xFFFF8001.
- Misaligned: word load at 0x0000_0002 and half load at 0x0000_0001 -> misalign pulse, mem_req stays 0, stall 0.
- Timeout: no ack, TIMEOUT=15 -> mem_req high for exactly 15 cycles, then bus_err pulse, stall 0, back in IDLE; a following legal request is accepted.
- Reset mid-REQ: pull RST low during a wait -> mem_req and stall go 0 immediately. After release, no ld_valid and no bus_err appear.
